// File: rtl/expu_stream_ctrl.sv
// Control sequencer for the exponential unit: runs one vector job through the
// unit with valid/ready on both sides, tracks in-flight stages, stalls and clears.
module expu_stream_ctrl #(
    parameter int LATENCY   = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o,
    output logic                 expu_enable_o,
    output logic                 expu_clear_o
);

    // Handshake: a beat transfers on a cycle where valid and ready are both high;
    // valid never depends on ready on the same side, ready may depend on valid downstream.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLEAR} state_t;

    state_t               state_q, state_d;
    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_WIDTH-1:0] emit_cnt_q, emit_cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic                 completed_q, completed_d;
    logic                 done_q, done_d;
    logic                 stall, accept, emit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            acc_cnt_q   <= '0;
            emit_cnt_q  <= '0;
            len_q       <= '0;
            completed_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            acc_cnt_q   <= acc_cnt_d;
            emit_cnt_q  <= emit_cnt_d;
            len_q       <= len_d;
            completed_q <= completed_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        vld_d         = vld_q;
        acc_cnt_d     = acc_cnt_q;
        emit_cnt_d    = emit_cnt_q;
        len_d         = len_q;
        completed_d   = completed_q;
        done_d        = 1'b0;
        expu_enable_o = 1'b0;
        expu_clear_o  = 1'b0;
        in_ready_o    = 1'b0;
        out_valid_o   = 1'b0;
        out_last_o    = 1'b0;
        accept        = 1'b0;
        emit          = 1'b0;
        stall         = vld_q[LATENCY-1] & ~out_ready_i;

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    len_d      = len_i;
                    acc_cnt_d  = '0;
                    emit_cnt_d = '0;
                    if (len_i != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d     = CLEAR;
                        completed_d = 1'b1;
                    end
                end
            end
            RUN, DRAIN: begin
                expu_enable_o = ~stall & ~abort_i;
                out_valid_o   = vld_q[LATENCY-1] & ~abort_i;
                in_ready_o    = (state_q == RUN) & expu_enable_o & (acc_cnt_q != len_q);
                accept        = in_valid_i & in_ready_o;
                emit          = out_valid_o & out_ready_i;
                out_last_o    = out_valid_o & (emit_cnt_q == len_q - CNT_WIDTH'(1));

                // The whole pipeline advances together, so vld only moves on enabled cycles.
                if (expu_enable_o) begin
                    for (int i = LATENCY - 1; i > 0; i--) begin
                        vld_d[i] = vld_q[i-1];
                    end
                    vld_d[0] = accept;
                end
                if (accept) acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
                if (emit) emit_cnt_d = emit_cnt_q + CNT_WIDTH'(1);

                if (abort_i) begin
                    state_d     = CLEAR;
                    completed_d = 1'b0;
                end else if (emit && (emit_cnt_q + CNT_WIDTH'(1) == len_q)) begin
                    state_d     = CLEAR;
                    completed_d = 1'b1;
                end else if (accept && (acc_cnt_q + CNT_WIDTH'(1) == len_q)) begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                expu_clear_o = 1'b1;
                vld_d        = '0;
                done_d       = completed_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_expu_stream_ctrl.sv
// Directed bench for expu_stream_ctrl: per-element expected out_last flags are
// queued on accept and compared on emit, plus timing/count checks per job.
module tb_expu_stream_ctrl;

    localparam int LAT = 2;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy_o, done_o, in_ready_o, out_valid_o, out_last_o;
    logic          expu_enable_o, expu_clear_o;

    expu_stream_ctrl #(.LATENCY(LAT), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .abort_i(abort),
        .busy_o(busy_o), .done_o(done_o), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_last_o(out_last_o),
        .expu_enable_o(expu_enable_o), .expu_clear_o(expu_clear_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [0:0] exp_q[$];
    int cur_len;
    int acc_m, emit_m, valid_m, last_m, clear_m, done_m;
    int first_acc, last_acc, first_val, clear_cyc, done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: push on accept, pop/compare on emit, count job-level events.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready_o) begin
                exp_q.push_back((acc_m == cur_len - 1) ? 1'b1 : 1'b0);
                if (acc_m == 0) first_acc = cyc;
                last_acc = cyc;
                acc_m++;
            end
            if (out_valid_o) valid_m++;
            if (out_valid_o && out_ready) begin
                if (emit_m == 0) first_val = cyc;
                if (exp_q.size() == 0) begin
                    chk("emit_underflow", 32'd1, 32'd0);
                end else begin
                    logic [0:0] e;
                    e = exp_q.pop_front();
                    chk("out_last", {31'd0, out_last_o}, {31'd0, e});
                end
                if (out_last_o) last_m++;
                emit_m++;
            end
            if (expu_clear_o) begin clear_m++; clear_cyc = cyc; end
            if (done_o) begin done_m++; done_cyc = cyc; end
        end
    end

    task automatic clr_mon();
        exp_q.delete();
        acc_m = 0; emit_m = 0; valid_m = 0; last_m = 0; clear_m = 0; done_m = 0;
        first_acc = -1; last_acc = -1; first_val = -1; clear_cyc = -1; done_cyc = -1;
    endtask

    task automatic start_job(input int n);
        @(posedge clk); #1;
        clr_mon();
        cur_len = n;
        start = 1'b1;
        len = CW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin got = 1'b1; break; end
        end
        chk(tag, {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic wait_acc(input string tag, input int n, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (acc_m >= n) begin got = 1'b1; break; end
        end
        chk(tag, {31'd0, got}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready_o}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid_o}, 32'd0);
        chk({tag, "_out_last"}, {31'd0, out_last_o}, 32'd0);
        chk({tag, "_enable"}, {31'd0, expu_enable_o}, 32'd0);
        chk({tag, "_clear"}, {31'd0, expu_clear_o}, 32'd0);
    endtask

    initial begin
        logic [5:0] pat;
        bit got;
        clr_mon();
        cur_len = 0;

        // Reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Job 1: len=4, free-flowing
        in_valid = 1'b1;
        out_ready = 1'b1;
        start_job(4);
        wait_done("j1_done", 40);
        chk("j1_accepts", acc_m, 4);
        chk("j1_accept_span", last_acc - first_acc, 3);
        chk("j1_first_valid_lat", first_val - first_acc, LAT);
        chk("j1_emits", emit_m, 4);
        chk("j1_last_cnt", last_m, 1);
        chk("j1_clear_cycles", clear_m, 1);
        chk("j1_done_after_clear", done_cyc - clear_cyc, 1);
        chk("j1_done_cnt", done_m, 1);
        chk("j1_q_empty", exp_q.size(), 0);

        // Job 2: len=4 with 3-cycle downstream stall while output is valid
        start_job(4);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid_o === 1'b1) begin got = 1'b1; break; end
        end
        chk("j2_valid_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("j2_stall_enable", {31'd0, expu_enable_o}, 32'd0);
            chk("j2_stall_in_ready", {31'd0, in_ready_o}, 32'd0);
            chk("j2_stall_valid_held", {31'd0, out_valid_o}, 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("j2_done", 40);
        chk("j2_emits", emit_m, 4);
        chk("j2_accepts", acc_m, 4);
        chk("j2_last_cnt", last_m, 1);
        chk("j2_q_empty", exp_q.size(), 0);

        // Job 3: len=3 with input bubbles 1,0,0,1,0,1
        in_valid = 1'b0;
        pat = 6'b101001;
        start_job(3);
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_done("j3_done", 40);
        chk("j3_accept_span", last_acc - first_acc, 5);
        chk("j3_first_valid_lat", first_val - first_acc, LAT);
        chk("j3_valid_beats", valid_m, 3);
        chk("j3_emits", emit_m, 3);
        chk("j3_last_cnt", last_m, 1);
        chk("j3_q_empty", exp_q.size(), 0);

        // Job 4: len=0 goes straight through CLEAR
        in_valid = 1'b1;
        start_job(0);
        wait_done("j4_done", 10);
        chk("j4_clear_cycles", clear_m, 1);
        chk("j4_done_after_clear", done_cyc - clear_cyc, 1);
        chk("j4_done_cnt", done_m, 1);
        chk("j4_valid_beats", valid_m, 0);

        // Job 5: len=8, abort after 5 accepts
        start_job(8);
        wait_acc("j5_reach5", 5, 30);
        #1;
        abort = 1'b1;
        @(negedge clk);
        chk("j5_abort_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("j5_abort_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("j5_abort_enable", {31'd0, expu_enable_o}, 32'd0);
        chk("j5_abort_emits", emit_m, 3);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("j5_clear", {31'd0, expu_clear_o}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("j5_no_done", done_m, 0);
        chk("j5_busy_after", {31'd0, busy_o}, 32'd0);
        chk("j5_accepts", acc_m, 5);

        // Job 6: reset during DRAIN, then a fresh len=2 job
        out_ready = 1'b0;
        start_job(2);
        wait_acc("j6_reach2", 2, 20);
        #1;
        in_valid = 1'b0;
        chk("j6_drain_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("j6_drain_busy", {31'd0, busy_o}, 32'd1);
        chk("j6_drain_out_valid", {31'd0, out_valid_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("j6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        start_job(2);
        wait_done("j6_done", 30);
        chk("j6_emits", emit_m, 2);
        chk("j6_last_cnt", last_m, 1);
        chk("j6_done_cnt", done_m, 1);
        chk("j6_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/expu_stream_ctrl.md
Name: expu_stream_ctrl

Overview:
- Control-only sequencer for the exponential unit pipeline. It runs one vector job of programmable length through the unit using valid/ready handshakes on both sides.
- It drives the unit's enable_i and clear_i and tracks which pipeline stages hold valid data. It stalls the whole pipeline on downstream backpressure, then drains and clears the unit at job end or on abort.
- Data does not pass through this block: the top level wires the input data straight to the unit's float_i, and the unit's float_o straight to the output data bus.

Parameters:
- LATENCY, 2, number of enabled clock edges from float_i capture to a valid float_o (must be >= 1).
- CNT_WIDTH, 16, width of the job length and of the element counters.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  job start; sampled only in IDLE
- len_i  input  CNT_WIDTH  job element count; latched with start_i
- abort_i  input  1  abandon the current job
- busy_o  output  1  high in any state other than IDLE
- done_o  output  1  one-cycle pulse on normal job completion
- in_valid_i  input  1  upstream element valid
- in_ready_o  output  1  element accepted when in_valid_i and in_ready_o are both high
- out_valid_o  output  1  unit output valid
- out_ready_i  input  1  downstream ready
- out_last_o  output  1  qualifies the final element of the job
- expu_enable_o  output  1  drives the unit's enable_i
- expu_clear_o  output  1  drives the unit's clear_i

Behaviour:
- Reset: state is IDLE; the vld[LATENCY-1:0] shift register, acc_cnt, emit_cnt and len_q are all 0. Every output is 0.
- States: IDLE, RUN, DRAIN, CLEAR. Every output below is combinational from state and registers, except done_o.
- IDLE:
  - expu_enable_o=0; in_ready_o=0; out_valid_o=0.
  - start_i & ~abort_i: latch len_i into len_q and zero both counters.
  - Then go to RUN if len_i != 0, otherwise to CLEAR.
- Stall signal: stall = vld[LATENCY-1] & ~out_ready_i.
- RUN and DRAIN:
  - expu_enable_o = ~stall & ~abort_i.
  - out_valid_o = vld[LATENCY-1] & ~abort_i.
  - On every cycle with expu_enable_o=1, vld shifts by one; the new vld[0] = in_valid_i & in_ready_o.
  - A cycle with expu_enable_o=0 holds vld unchanged.
- RUN input side:
  - in_ready_o = expu_enable_o & (acc_cnt != len_q).
  - An accepted element increments acc_cnt.
  - When the accept brings acc_cnt to len_q: go to DRAIN, unless the emit condition below fires in the same cycle.
- Emit (RUN or DRAIN): out_valid_o & out_ready_i increments emit_cnt.
  - out_last_o = out_valid_o & (emit_cnt == len_q-1).
  - An emit that brings emit_cnt to len_q goes to CLEAR, from either state.
- DRAIN: in_ready_o=0.
- CLEAR (exactly 1 cycle):
  - expu_clear_o=1; expu_enable_o=0; in_ready_o=0; out_valid_o=0.
  - vld is zeroed. Next state is IDLE.
  - done_o pulses high in the cycle after CLEAR, only if CLEAR was reached by normal completion (including len=0).
- Abort:
  - abort_i in RUN or DRAIN forces in_ready_o, out_valid_o and expu_enable_o to 0 in that same cycle; next state is CLEAR.
  - After an abort, done_o is not pulsed.
  - abort_i in IDLE or CLEAR has no effect beyond the IDLE start suppression.
- start_i is ignored outside IDLE.
- Counters are CNT_WIDTH bits and never wrap: acc_cnt <= len_q and emit_cnt <= len_q by construction.
- Reset mid-job immediately returns the block to its reset state. The unit shares rst_ni, so no clear pulse is needed.

Test Plan:
- len=4, in_valid_i and out_ready_i held high → 4 accepts on consecutive cycles; first out_valid_o LATENCY cycles after the first accept; out_last_o on the 4th emit; CLEAR for 1 cycle; done_o pulse on the next cycle.
- len=4, out_ready_i low for 3 cycles while vld[LATENCY-1]=1 → expu_enable_o=0, in_ready_o=0 and vld frozen for those 3 cycles; no element lost or duplicated; emit_cnt reaches 4.
- len=3, input bubbles (in_valid_i pattern 1,0,0,1,0,1) → vld carries matching holes; exactly 3 out_valid_o beats; out_last_o only on the 3rd.
- start with len=0 → IDLE → CLEAR → IDLE; expu_clear_o high for 1 cycle; done_o pulse; out_valid_o never asserted.
- len=8, abort_i after 5 accepts with 2 elements in flight → same cycle: out_valid_o=0 and in_ready_o=0; next cycle: expu_clear_o=1; no done_o pulse; busy_o=0 afterwards.
- rst_ni low during DRAIN → all outputs 0 immediately; a new start with len=2 after release completes normally.
